uart_loader: RTL
================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address width of the target instruction memory.
REQ-002 SHALL have port clock  input  1  system clock; single clock domain for all internal state.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rxData  input  8  received byte from the UART receiver; stable while rxFin is high.
REQ-005 SHALL have port rxFin  input  1  receiver byte-complete flag, asynchronous to clock, high for at least 2 clock periods.
REQ-006 SHALL have port memWriteEnable  output  1  one-cycle word write strobe.
REQ-007 SHALL have port memAddress  output  ADDR_WIDTH  word address of the current write.
REQ-008 SHALL have port memWriteData  output  32  assembled word.
REQ-009 SHALL have port cpuReset  output  1  active-low CPU reset; low until load completes.
REQ-010 SHALL have port loadDone  output  1  high once the image is fully written.
REQ-011 SHALL have port checksum  output  8  running XOR of all payload bytes.

Function
REQ-012 SHALL pass rxFin through a 2-flop synchronizer, then rising-edge detect; each detected edge is one byte event, and rxData is sampled on that event cycle.
REQ-013 SHALL ignore rxFin held high: one event per low-to-high transition only.
REQ-014 SHALL implement states LEN_LO, LEN_HI, DATA, DONE; reset state LEN_LO.
REQ-015 LEN_LO: on byte event, store byte as wordCount[7:0], go to LEN_HI.
REQ-016 LEN_HI: on byte event, store byte as wordCount[15:8]; if resulting wordCount==0 go to DONE, else go to DATA with byteIndex=0, memAddress=0.
REQ-017 DATA: on each byte event, place byte at lane byteIndex (byte 0 -> bits 7:0, little-endian), XOR into checksum, increment byteIndex modulo 4.
REQ-018 DATA: on the event completing lane 3, assert memWriteEnable for exactly the next clock cycle, with memWriteData the full word and memAddress the word's address.
REQ-019 SHALL increment memAddress in the cycle after each write strobe, wrapping modulo 2^ADDR_WIDTH; wordCount beyond 2^ADDR_WIDTH overwrites from address 0.
REQ-020 SHALL decrement a remaining-word counter per write; transition to DONE in the same cycle the final strobe is issued.
REQ-021 DONE: ignore all further byte events; checksum, memAddress and memWriteData hold; memWriteEnable stays 0.
REQ-022 SHALL drive loadDone=1 and cpuReset=1 combinationally from state==DONE; both 0 in every other state.
REQ-023 memWriteData SHALL hold its last value between strobes; partial words (bytes 0-2) SHALL never be written.
REQ-024 A byte event arriving in the strobe cycle SHALL be accepted without loss.
REQ-025 Header bytes SHALL NOT be included in checksum.

Reset
REQ-026 On reset low, immediately: state=LEN_LO, memWriteEnable=0, memAddress=0, memWriteData=0, checksum=0, byteIndex=0, wordCount=0, synchronizer flops=0, cpuReset=0, loadDone=0.
REQ-027 Reset asserted mid-load SHALL abandon the transfer; the next load restarts from a new header at address 0.
REQ-028 After reset release, an rxFin already high SHALL NOT produce an event until it falls and rises again.

Verification
REQ-029 Header 0x02,0x00 then bytes 11 22 33 44 55 66 77 88 -> strobes: addr 0 data 0x44332211, addr 1 data 0x88776655; loadDone=1, cpuReset=1, checksum=0x88.
REQ-030 Header 0x00,0x00 -> DONE immediately after second byte, no strobes, checksum=0x00.
REQ-031 rxFin held high 50 cycles per byte with header 0x01,0x00 and bytes AA BB CC DD -> exactly one strobe, data 0xDDCCBBAA, addr 0.
REQ-032 ADDR_WIDTH=2, header 0x05,0x00, 20 bytes -> addresses 0,1,2,3,0; fifth word overwrites address 0.
REQ-033 Reset pulsed after 6 payload bytes of a 2-word load, then full 1-word load 01 00 01 02 03 04 -> single strobe addr 0 data 0x04030201, checksum=0x04.
REQ-034 Extra bytes after DONE -> no strobe, outputs unchanged.

Source files
------------

// File: rtl/uart_loader.sv
// Boot loader: assembles little-endian words from a UART byte stream and
// writes them to instruction memory, holding the CPU in reset until done.
module uart_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rxData,
    input  logic                  rxFin,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memWriteData,
    output logic                  cpuReset,
    output logic                  loadDone,
    output logic [7:0]            checksum
);

    typedef enum logic [1:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic        finMeta;
    logic        finSync;
    logic        finPrev;
    logic [1:0]  settle;
    logic        armed;
    logic        byteEvent;

    logic [15:0] wordCount;
    logic [15:0] remaining;
    logic [1:0]  byteIndex;
    logic [23:0] partial;

    // Events are armed only after the synchronized flag is seen low, so a
    // flag already high at reset release cannot masquerade as a new byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finMeta <= 1'b0;
            finSync <= 1'b0;
            finPrev <= 1'b0;
            settle  <= 2'd0;
            armed   <= 1'b0;
        end else begin
            finMeta <= rxFin;
            finSync <= finMeta;
            finPrev <= finSync;
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (settle == 2'd2 && !finSync)
                armed <= 1'b1;
        end
    end

    assign byteEvent = armed & finSync & ~finPrev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= LEN_LO;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            LEN_LO: begin
                if (byteEvent)
                    stateNext = LEN_HI;
            end
            LEN_HI: begin
                if (byteEvent)
                    stateNext = ({rxData, wordCount[7:0]} == 16'd0) ? DONE : DATA;
            end
            DATA: begin
                if (byteEvent && byteIndex == 2'd3 && remaining == 16'd1)
                    stateNext = DONE;
            end
            DONE: stateNext = DONE;
        endcase
    end

    assign loadDone = (state == DONE);
    assign cpuReset = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memWriteData   <= 32'd0;
            checksum       <= 8'd0;
            wordCount      <= 16'd0;
            remaining      <= 16'd0;
            byteIndex      <= 2'd0;
            partial        <= 24'd0;
        end else begin
            memWriteEnable <= 1'b0;
            // The final word's address is held once loading has finished.
            if (memWriteEnable && state != DONE)
                memAddress <= memAddress + ADDR_WIDTH'(1);
            if (byteEvent) begin
                unique case (state)
                    LEN_LO: wordCount[7:0] <= rxData;
                    LEN_HI: begin
                        wordCount[15:8] <= rxData;
                        remaining       <= {rxData, wordCount[7:0]};
                        byteIndex       <= 2'd0;
                        memAddress      <= '0;
                    end
                    DATA: begin
                        checksum  <= checksum ^ rxData;
                        byteIndex <= byteIndex + 2'd1;
                        if (byteIndex == 2'd3) begin
                            memWriteData   <= {rxData, partial};
                            memWriteEnable <= 1'b1;
                            remaining      <= remaining - 16'd1;
                        end else begin
                            partial[{byteIndex, 3'b000} +: 8] <= rxData;
                        end
                    end
                    DONE: ;
                endcase
            end
        end
    end

endmodule
